// File: rtl/nx_axi4s_bridge.sv
// AXI4-stream <-> Nexus control-stream width bridge.
// Inbound beats are serialised into control words; outbound words are packed into beats.
module nx_axi4s_bridge #(
   parameter int AXI4_DATA_WIDTH = 128,
   parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH/8,
   parameter int CTRL_WIDTH      = 32,
   parameter int MAX_PKT_BEATS   = 16,
   parameter int FLUSH_CYCLES    = 64
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [AXI4_DATA_WIDTH-1:0] inbound_tdata,
   input  logic                       inbound_tlast,
   input  logic                       inbound_tvalid,
   output logic                       inbound_tready,
   output logic [CTRL_WIDTH-1:0]      o_ctrl_in_data,
   output logic                       o_ctrl_in_valid,
   input  logic                       i_ctrl_in_ready,
   input  logic [CTRL_WIDTH-1:0]      i_ctrl_out_data,
   input  logic                       i_ctrl_out_valid,
   output logic                       o_ctrl_out_ready,
   output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
   output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep,
   output logic                       outbound_tlast,
   output logic                       outbound_tvalid,
   input  logic                       outbound_tready
);
   localparam int RATIO = AXI4_DATA_WIDTH / CTRL_WIDTH;
   localparam int LB    = CTRL_WIDTH / 8;
   localparam int CW    = $clog2(RATIO);
   localparam int PW    = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;
   localparam int TW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam bit FLUSH_EN = FLUSH_CYCLES > 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
   localparam logic [PW-1:0] PKT_LAST = PW'(MAX_PKT_BEATS - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(FLUSH_EN ? FLUSH_CYCLES - 1 : 0);

   logic unused_tlast;
   assign unused_tlast = inbound_tlast;

   logic [RATIO-1:0][CTRL_WIDTH-1:0] in_lane;
   logic [RATIO-1:0] in_mask, in_left, beat_mask;
   logic [CW-1:0]    in_sel;
   logic             in_busy, in_hs, in_acc;

   // Lowest pending lane goes out first
   always_comb begin
      in_sel = '0;
      for (int i = RATIO - 1; i >= 0; i--)
         if (in_mask[i]) in_sel = CW'(i);
   end

   always_comb begin
      beat_mask = '0;
      for (int i = 0; i < RATIO; i++)
         beat_mask[i] = |inbound_tdata[i*CTRL_WIDTH +: CTRL_WIDTH];
   end

   assign in_left  = in_mask & ~(RATIO'(1) << in_sel);
   assign in_busy  = |in_mask;
   assign in_hs    = in_busy & i_ctrl_in_ready;
   assign inbound_tready  = rstn & (~in_busy | (in_hs & ~|in_left));
   assign in_acc   = inbound_tvalid & inbound_tready;
   assign o_ctrl_in_valid = in_busy;
   assign o_ctrl_in_data  = in_busy ? in_lane[in_sel] : '0;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         in_lane <= '0;
         in_mask <= '0;
      end else if (in_acc) begin
         in_lane <= inbound_tdata;
         in_mask <= beat_mask;
      end else if (in_hs) begin
         in_mask <= in_left;
      end
   end

   logic [RATIO-1:0][CTRL_WIDTH-1:0] acc, acc_next;
   logic [AXI4_STRB_WIDTH-1:0] part_keep;
   logic [CW-1:0] cnt;
   logic [PW-1:0] pkt;
   logic [TW-1:0] tmr;
   logic can_load, wacc, full, flush, load, end_pkt;

   assign can_load = ~outbound_tvalid | outbound_tready;
   assign o_ctrl_out_ready = rstn & can_load;
   assign wacc  = i_ctrl_out_valid & o_ctrl_out_ready;
   assign full  = wacc & (cnt == CNT_LAST);
   // An arriving word always wins over a due flush
   assign flush = FLUSH_EN & ~wacc & can_load & (cnt != '0) & (tmr == TMR_LAST);
   assign load  = full | flush;
   assign end_pkt = flush | (pkt == PKT_LAST);

   always_comb begin
      acc_next = acc;
      if (wacc) acc_next[cnt] = i_ctrl_out_data;
   end

   always_comb begin
      part_keep = '0;
      for (int i = 0; i < RATIO; i++)
         if (i < int'(cnt)) part_keep[i*LB +: LB] = {LB{1'b1}};
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc <= '0;
         cnt <= '0;
         pkt <= '0;
         tmr <= '0;
         outbound_tdata  <= '0;
         outbound_tkeep  <= '0;
         outbound_tlast  <= 1'b0;
         outbound_tvalid <= 1'b0;
      end else begin
         if (outbound_tready) outbound_tvalid <= 1'b0;
         if (load) begin
            outbound_tvalid <= 1'b1;
            outbound_tdata  <= acc_next;
            outbound_tkeep  <= full ? '1 : part_keep;
            outbound_tlast  <= end_pkt;
            pkt <= end_pkt ? '0 : pkt + 1'b1;
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_next;
            if (wacc) cnt <= cnt + 1'b1;
         end
         if (wacc || cnt == '0 || flush) tmr <= '0;
         else if (tmr != TMR_LAST) tmr <= tmr + 1'b1;
      end
   end
endmodule

// File: tb/tb_nx_axi4s_bridge.sv
// Bench for nx_axi4s_bridge: directed plan steps plus randomised traffic
// checked against a queue-based model of both stream directions.
module tb_nx_axi4s_bridge;
   localparam int DW = 128;
   localparam int KW = 16;
   localparam int CW = 32;
   localparam int R = 4;
   localparam int MAXB = 2;
   localparam int FL = 8;

   logic clk = 0;
   logic rstn;
   logic [DW-1:0] inbound_tdata;
   logic inbound_tlast, inbound_tvalid, inbound_tready;
   logic [CW-1:0] o_ctrl_in_data;
   logic o_ctrl_in_valid, i_ctrl_in_ready;
   logic [CW-1:0] i_ctrl_out_data;
   logic i_ctrl_out_valid, o_ctrl_out_ready;
   logic [DW-1:0] outbound_tdata;
   logic [KW-1:0] outbound_tkeep;
   logic outbound_tlast, outbound_tvalid, outbound_tready;

   nx_axi4s_bridge #(
      .AXI4_DATA_WIDTH(DW),
      .CTRL_WIDTH(CW),
      .MAX_PKT_BEATS(MAXB),
      .FLUSH_CYCLES(FL)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .inbound_tdata(inbound_tdata),
      .inbound_tlast(inbound_tlast),
      .inbound_tvalid(inbound_tvalid),
      .inbound_tready(inbound_tready),
      .o_ctrl_in_data(o_ctrl_in_data),
      .o_ctrl_in_valid(o_ctrl_in_valid),
      .i_ctrl_in_ready(i_ctrl_in_ready),
      .i_ctrl_out_data(i_ctrl_out_data),
      .i_ctrl_out_valid(i_ctrl_out_valid),
      .o_ctrl_out_ready(o_ctrl_out_ready),
      .outbound_tdata(outbound_tdata),
      .outbound_tkeep(outbound_tkeep),
      .outbound_tlast(outbound_tlast),
      .outbound_tvalid(outbound_tvalid),
      .outbound_tready(outbound_tready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic l;
   } beat_t;

   int checks = 0;
   int passes = 0;
   logic [CW-1:0] in_q[$];
   logic [CW-1:0] pend[$];
   beat_t out_q[$];
   int pkt = 0;
   int idle = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic make_beat(input bit fl);
      beat_t b;
      b.d = '0;
      b.k = '0;
      foreach (pend[i]) begin
         b.d[i*CW +: CW] = pend[i];
         b.k[i*4 +: 4] = 4'hF;
      end
      b.l = fl || (pkt == MAXB - 1);
      pkt = b.l ? 0 : pkt + 1;
      out_q.push_back(b);
      pend.delete();
   endtask

   // Sampled mid-cycle: compare against model, then advance the model
   task automatic observe();
      bit can_load, wacc;
      logic [DW-1:0] d;
      chk("in_valid", 128'(o_ctrl_in_valid), 128'(in_q.size() != 0));
      chk("in_tready", 128'(inbound_tready),
          128'(in_q.size() == 0 || (in_q.size() == 1 && i_ctrl_in_ready)));
      if (in_q.size() != 0) begin
         chk("in_word", 128'(o_ctrl_in_data), 128'(in_q[0]));
         if (i_ctrl_in_ready) void'(in_q.pop_front());
      end
      if (inbound_tvalid && inbound_tready) begin
         d = inbound_tdata;
         for (int i = 0; i < R; i++)
            if (d[i*CW +: CW] != 0) in_q.push_back(d[i*CW +: CW]);
      end
      can_load = out_q.size() == 0 || outbound_tready;
      chk("out_valid", 128'(outbound_tvalid), 128'(out_q.size() != 0));
      chk("ctrl_out_ready", 128'(o_ctrl_out_ready), 128'(can_load));
      if (out_q.size() != 0) begin
         chk("out_data", outbound_tdata, out_q[0].d);
         chk("out_keep", 128'(outbound_tkeep), 128'(out_q[0].k));
         chk("out_last", 128'(outbound_tlast), 128'(out_q[0].l));
         if (outbound_tready) void'(out_q.pop_front());
      end
      wacc = i_ctrl_out_valid && can_load;
      if (wacc) begin
         pend.push_back(i_ctrl_out_data);
         idle = 0;
         if (pend.size() == R) make_beat(0);
      end else if (pend.size() != 0) begin
         idle++;
         if (idle >= FL && can_load) begin
            make_beat(1);
            idle = 0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 0;
      inbound_tvalid = 1;
      @(posedge clk);
      #1;
      chk("rst_in_tready", 128'(inbound_tready), 0);
      chk("rst_in_valid", 128'(o_ctrl_in_valid), 0);
      chk("rst_in_data", 128'(o_ctrl_in_data), 0);
      chk("rst_out_ready", 128'(o_ctrl_out_ready), 0);
      chk("rst_tvalid", 128'(outbound_tvalid), 0);
      chk("rst_tdata", outbound_tdata, 0);
      chk("rst_tkeep", 128'(outbound_tkeep), 0);
      chk("rst_tlast", 128'(outbound_tlast), 0);
      in_q.delete();
      pend.delete();
      out_q.delete();
      pkt = 0;
      idle = 0;
      inbound_tvalid = 0;
      i_ctrl_out_valid = 0;
      rstn = 1;
   endtask

   task automatic send_word(input logic [CW-1:0] w);
      i_ctrl_out_valid = 1;
      i_ctrl_out_data = w;
      cycle();
      i_ctrl_out_valid = 0;
   endtask

   initial begin
      int n;
      logic [DW-1:0] snap;
      inbound_tdata = '0;
      inbound_tlast = 0;
      inbound_tvalid = 0;
      i_ctrl_in_ready = 1;
      i_ctrl_out_data = '0;
      i_ctrl_out_valid = 0;
      outbound_tready = 1;
      do_reset();

      // Serialise a full beat
      inbound_tvalid = 1;
      inbound_tdata = 128'h00000004_00000003_00000002_00000001;
      cycle();
      inbound_tvalid = 0;
      for (int k = 1; k <= 4; k++) begin
         chk("ser_valid", 128'(o_ctrl_in_valid), 1);
         chk("ser_word", 128'(o_ctrl_in_data), 128'(k));
         if (k == 4) chk("ser_tready_last", 128'(inbound_tready), 1);
         cycle();
      end
      // Padding lanes skipped
      inbound_tvalid = 1;
      inbound_tdata = 128'h00000000_00000009_00000000_00000007;
      cycle();
      inbound_tvalid = 0;
      chk("skip_w0", 128'(o_ctrl_in_data), 128'h7);
      cycle();
      chk("skip_w1", 128'(o_ctrl_in_data), 128'h9);
      cycle();
      chk("skip_done", 128'(o_ctrl_in_valid), 0);
      // All-zero beat dropped
      inbound_tvalid = 1;
      inbound_tdata = '0;
      chk("zero_tready", 128'(inbound_tready), 1);
      cycle();
      inbound_tvalid = 0;
      chk("zero_novalid", 128'(o_ctrl_in_valid), 0);
      cycle();

      // Packing 8 words
      for (int k = 0; k < 8; k++) begin
         send_word(32'h10 + 32'(k));
         if (k == 3) begin
            chk("pack0", outbound_tdata, 128'h00000013_00000012_00000011_00000010);
            chk("pack0_keep", 128'(outbound_tkeep), 128'hFFFF);
            chk("pack0_last", 128'(outbound_tlast), 0);
         end
      end
      chk("pack1", outbound_tdata, 128'h00000017_00000016_00000015_00000014);
      chk("pack1_last", 128'(outbound_tlast), 1);
      cycle();

      // Idle flush
      send_word(32'hAB);
      n = 0;
      while (n < 20 && !outbound_tvalid) begin
         cycle();
         n++;
      end
      chk("flush_lat", 128'(n), 8);
      chk("flush_data", outbound_tdata, 128'hAB);
      chk("flush_keep", 128'(outbound_tkeep), 128'h000F);
      chk("flush_last", 128'(outbound_tlast), 1);
      cycle();
      // Word on the flush cycle prevents flush
      send_word(32'hCD);
      for (int k = 0; k < 7; k++) cycle();
      send_word(32'hEF);
      for (int k = 0; k < 5; k++) cycle();
      chk("noflush", 128'(outbound_tvalid), 0);
      send_word(32'h01);
      send_word(32'h02);
      chk("cnt2_beat", outbound_tdata, 128'h00000002_00000001_000000EF_000000CD);
      chk("cnt2_keep", 128'(outbound_tkeep), 128'hFFFF);
      cycle();

      // Backpressure
      outbound_tready = 0;
      for (int k = 0; k < 4; k++) send_word(32'h30 + 32'(k));
      snap = outbound_tdata;
      i_ctrl_out_valid = 1;
      i_ctrl_out_data = 32'h40;
      for (int k = 0; k < 3; k++) begin
         chk("bp_ready", 128'(o_ctrl_out_ready), 0);
         cycle();
         chk("bp_stable", outbound_tdata, snap);
      end
      outbound_tready = 1;
      #1;
      chk("bp_release", 128'(o_ctrl_out_ready), 1);
      cycle();
      i_ctrl_out_valid = 0;
      cycle();

      // Reset mid-transfer
      i_ctrl_in_ready = 1;
      inbound_tvalid = 1;
      inbound_tdata = 128'h0000000D_0000000C_0000000B_0000000A;
      cycle();
      inbound_tvalid = 0;
      cycle();
      cycle();
      i_ctrl_in_ready = 0;
      send_word(32'h55);
      send_word(32'h66);
      do_reset();
      i_ctrl_in_ready = 1;
      for (int k = 0; k < 14; k++) cycle();

      // Random traffic
      for (int blk = 0; blk < 12; blk++) begin
         int dens;
         dens = $urandom_range(1, 10);
         for (int c = 0; c < 60; c++) begin
            inbound_tvalid = $urandom_range(0, 1) == 1;
            for (int i = 0; i < R; i++)
               inbound_tdata[i*CW +: CW] = ($urandom_range(0, 1) == 1) ? $urandom : 0;
            i_ctrl_in_ready = $urandom_range(0, 3) != 0;
            i_ctrl_out_valid = $urandom_range(1, 10) <= dens;
            i_ctrl_out_data = $urandom;
            outbound_tready = $urandom_range(0, 3) != 0;
            cycle();
         end
      end
      inbound_tvalid = 0;
      i_ctrl_out_valid = 0;
      i_ctrl_in_ready = 1;
      outbound_tready = 1;
      for (int k = 0; k < 20; k++) cycle();
      chk("drain_in", 128'(in_q.size()), 0);
      chk("drain_out", 128'(out_q.size() + pend.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
